mdu_ctrl: RTL
=============

# mdu_ctrl

Multi-cycle multiply/divide sequencer for the EX stage. It accepts MULT/MULTU/DIV/DIVU ops from the instruction in EX and runs them on an internal shift-add/shift-subtract core. While the op runs it drives `alu_stall_E` into the hazard unit, and it aborts cleanly when EX is flushed by a mispredict or an exception. It delivers a 64-bit HI/LO result with a one-cycle valid pulse when the op completes.

## Interface
- `MDU_ITER`, default 32: number of iteration cycles for the iterative multiply and divide.
- `clk`  in  1  clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `op_valid_E`  in  1  the instruction in EX is a mul/div op.
- `op_E`  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; any other code is ignored (no start).
- `a_E`, `b_E`  in  32 each  rs/rt operands, already forwarded.
- `flush_E`  in  1  the EX instruction is killed (pred failed).
- `flush_exception_M`  in  1  exception flush.
- `alu_stall_E`  out  1  stall request to the hazard unit.
- `result_hi`, `result_lo`  out  32 each  HI/LO result of the last completed op.
- `result_valid`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, MUL, DIV, DONE. The iteration counter `cnt` is 6 bits wide.
- `kill` = `flush_E | flush_exception_M`.
- IDLE, with `op_valid_E`, a legal `op_E` and no `kill`:
  - latch operands and op;
  - go to MUL or DIV with `cnt=0`.
  - DIV/DIVU with `b_E==0` instead goes straight to DONE with `lo=32'hFFFF_FFFF` and `hi=a_E`.
- MUL and DIV run one iteration per cycle.
  - After `cnt==MDU_ITER-1` the block goes to DONE.
  - Signed ops work on absolute values.
  - The sign fix-up is applied when entering DONE: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign; the product is negated if the signs differ.
- DONE:
  - `result_hi`/`result_lo` are updated on entry, so they are valid throughout DONE;
  - `result_valid=1`;
  - the next state is always IDLE.
  - `op_valid_E` is still high in DONE for the same instruction and must not restart it.
- `alu_stall_E = ~kill & ((IDLE & op_valid_E & legal op) | MUL | DIV)`. It is combinational, and it is low in DONE.
- `kill` in MUL or DIV:
  - next state is IDLE;
  - no `result_valid`;
  - `result_hi`/`result_lo` are unchanged.
- `kill` in DONE:
  - `result_valid` is still driven, because the commit decision belongs downstream;
  - next state is IDLE.
- Arithmetic:
  - product is 64-bit two's complement;
  - DIV `0x8000_0000 / -1` gives `lo=0x8000_0000`, `hi=0` (natural wrap, no trap).
- `rst` at any time, including mid-op: state IDLE, `cnt=0`, `result_hi=result_lo=0`, `alu_stall_E=0`, `result_valid=0`, effective the next edge.

## Timing
- Cycle 0 is the accept cycle; the stall is high in that cycle.
- Iterative op:
  - cycles 1..`MDU_ITER` are iterations;
  - DONE is at cycle `MDU_ITER+1` (33 by default);
  - the stall is high for exactly `MDU_ITER+1` cycles.
- Divide by zero: DONE at cycle 1; the stall is high for 1 cycle.
- The next op may be accepted in the cycle after DONE. The minimum spacing between ops is `MDU_ITER+2` cycles.
- `result_valid` is only ever high in DONE.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - MULT/MULTU bypass the iterative core;
  - a 32x32 signed/unsigned multiply is computed in the accept cycle and registered;
  - DONE is at cycle 1, with the stall high for 1 cycle.
- `MDU_FAST_MUL_EN` undefined: the multiply uses shift-add over `MDU_ITER` cycles. DIV timing is identical either way.

## Structure
- `mdu_pkg` holds:
  - the op codes (`MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`);
  - the state enum;
  - the default `MDU_ITER=32`.
- Sub-module `mdu_shift_core` is combinational: one shift-add step (multiply) or one restoring shift-subtract step (divide) on a 64-bit accumulator, plus the 32-bit operand. `mdu_ctrl` owns the FSM, counter, sign handling, flush logic and output registers.

## Test plan
- MULT `a=0xFFFF_FFFD` (-3), `b=7`:
  - required result `hi=0xFFFF_FFFF`, `lo=0xFFFF_FFEB`;
  - stall high 33 cycles, then `result_valid` for 1 cycle (fast build: stall 1 cycle, valid at cycle 1).
- DIVU `100/7`: `lo=14`, `hi=2`, valid at cycle 33. DIV `-7/2` (`0xFFFF_FFF9`, 2): `lo=0xFFFF_FFFD`, `hi=0xFFFF_FFFF`.
- DIV `0x8000_0000 / 0xFFFF_FFFF`: `lo=0x8000_0000`, `hi=0`. DIVU `5/0`: `lo=0xFFFF_FFFF`, `hi=5`, stall 1 cycle.
- `flush_exception_M` in cycle 10 of a DIV:
  - `alu_stall_E` low that cycle, IDLE next;
  - no `result_valid`; old HI/LO kept;
  - a new MULTU `3*4` in the next cycle gives `lo=12`.
- `op_valid_E` held high through DONE and one extra cycle with the same op: exactly one `result_valid` per accept. An illegal `op_E=5` causes no stall.
- `rst` at cycle 15 of a MULT: all outputs 0 the next cycle, and a fresh DIVU `9/3` afterwards gives `lo=3`, `hi=0`.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states,
// default iteration count and a conditional absolute-value helper.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;

    localparam int MDU_ITER_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // Magnitude of a two's complement value when en is set; 0x8000_0000 maps to itself,
    // which is the correct unsigned magnitude 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
        logic [31:0] r;
        if (en && v[31]) begin
            r = 32'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// One combinational iteration of the MDU core: shift-add multiply step or
// restoring shift-subtract divide step on a {hi,lo} 64-bit accumulator.
module mdu_shift_core
    import mdu_pkg::*;
(
    input  logic        i_div,
    input  logic [63:0] i_acc,
    input  logic [31:0] i_opnd,
    output logic [63:0] o_acc
);

    logic [32:0] w_sum;
    logic [32:0] w_diff;

    // Multiply shifts the partial product right; divide shifts the remainder left.
    always_comb begin
        w_sum  = {1'b0, i_acc[63:32]} + (i_acc[0] ? {1'b0, i_opnd} : 33'd0);
        w_diff = i_acc[63:31] - {1'b0, i_opnd};
        o_acc  = 64'd0;
        if (i_div) begin
            if (w_diff[32] == 1'b0) begin
                o_acc = {w_diff[31:0], i_acc[30:0], 1'b1};
            end else begin
                o_acc = {i_acc[62:0], 1'b0};
            end
        end else begin
            o_acc = {w_sum, i_acc[31:1]};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with EX stall and flush abort.
// Define MDU_FAST_MUL_EN to compute multiplies in the accept cycle.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MDU_ITER = MDU_ITER_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_op_valid_E,
    input  logic [2:0]  i_op_E,
    input  logic [31:0] i_a_E,
    input  logic [31:0] i_b_E,
    input  logic        i_flush_E,
    input  logic        i_flush_exception_M,
    output logic        o_alu_stall_E,
    output logic [31:0] o_result_hi,
    output logic [31:0] o_result_lo,
    output logic        o_result_valid
);

    mdu_state_e  r_state;
    mdu_state_e  w_next_state;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_opnd;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_valid;

    logic        w_kill;
    logic        w_legal;
    logic        w_start;
    logic        w_is_div;
    logic        w_signed_op;
    logic        w_last;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [63:0] w_core_acc;
    logic [63:0] w_mul_fix;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    assign w_kill      = i_flush_E | i_flush_exception_M;
    assign w_legal     = (i_op_E[2] == 1'b0);
    assign w_start     = (r_state == ST_IDLE) & i_op_valid_E & w_legal & ~w_kill;
    assign w_is_div    = (i_op_E == MDU_DIV) | (i_op_E == MDU_DIVU);
    assign w_signed_op = (i_op_E == MDU_MULT) | (i_op_E == MDU_DIV);
    assign w_last      = (r_cnt == 6'(MDU_ITER - 1));
    assign w_abs_a     = abs32(i_a_E, w_signed_op);
    assign w_abs_b     = abs32(i_b_E, w_signed_op);

    mdu_shift_core u_core (
        .i_div  (r_state == ST_DIV),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_core_acc)
    );

    // Quotient and product negate on differing signs; remainder follows the dividend.
    assign w_mul_fix  = r_neg_res ? (64'd0 - w_core_acc) : w_core_acc;
    assign w_quot_fix = r_neg_res ? (32'd0 - w_core_acc[31:0]) : w_core_acc[31:0];
    assign w_rem_fix  = r_neg_rem ? (32'd0 - w_core_acc[63:32]) : w_core_acc[63:32];

`ifdef MDU_FAST_MUL_EN
    logic [63:0] w_fast_prod;
    assign w_fast_prod = w_signed_op
        ? ({{32{i_a_E[31]}}, i_a_E} * {{32{i_b_E[31]}}, i_b_E})
        : ({32'd0, i_a_E} * {32'd0, i_b_E});
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and stall; DONE always returns to IDLE so a held op_valid never restarts it there.
    always_comb begin
        w_next_state  = r_state;
        o_alu_stall_E = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_alu_stall_E = ~w_kill & i_op_valid_E & w_legal;
                if (w_start) begin
                    if (w_is_div) begin
                        w_next_state = (i_b_E == 32'd0) ? ST_DONE : ST_DIV;
                    end else begin
`ifdef MDU_FAST_MUL_EN
                        w_next_state = ST_DONE;
`else
                        w_next_state = ST_MUL;
`endif
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                o_alu_stall_E = ~w_kill;
                if (w_kill) begin
                    w_next_state = ST_IDLE;
                end else if (w_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = r_state;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand latch, iteration, sign fix-up and result registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= 6'd0;
            r_acc     <= 64'd0;
            r_opnd    <= 32'd0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= (w_next_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_cnt     <= 6'd0;
                        r_acc     <= {32'd0, w_abs_a};
                        r_opnd    <= w_abs_b;
                        r_neg_res <= w_signed_op & (i_a_E[31] ^ i_b_E[31]);
                        r_neg_rem <= w_signed_op & i_a_E[31];
                        if (w_is_div && (i_b_E == 32'd0)) begin
                            r_hi <= i_a_E;
                            r_lo <= 32'hFFFF_FFFF;
                        end
`ifdef MDU_FAST_MUL_EN
                        else if (!w_is_div) begin
                            r_hi <= w_fast_prod[63:32];
                            r_lo <= w_fast_prod[31:0];
                        end
`endif
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (!w_kill) begin
                        r_acc <= w_core_acc;
                        r_cnt <= r_cnt + 6'd1;
                        if (w_last) begin
                            if (r_state == ST_MUL) begin
                                r_hi <= w_mul_fix[63:32];
                                r_lo <= w_mul_fix[31:0];
                            end else begin
                                r_hi <= w_rem_fix;
                                r_lo <= w_quot_fix;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_result_hi    = r_hi;
    assign o_result_lo    = r_lo;
    assign o_result_valid = r_valid;

endmodule
